// File: rtl/kyber_params_pkg.sv
// Shared Kyber parameters and the matrix-A generation scheduler state encoding.
package kyber_params_pkg;

    localparam int unsigned KYBER_K = 3;
    localparam int unsigned KYBER_N = 256;
    localparam int unsigned KYBER_Q = 3329;

    localparam int unsigned SLOT_W = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        XOF_REQ    = 3'd1,
        XOF_WAIT   = 3'd2,
        PARSE_REQ  = 3'd3,
        PARSE_WAIT = 3'd4,
        EMIT       = 3'd5,
        FIN        = 3'd6
    } sched_state_e;

endpackage

// File: rtl/gen_a_sched.sv
// Walks the K x K matrix A (or A^T), sequencing XOF, parse and sink handshakes
// for one polynomial at a time. All outputs are registered from next-state values.
module gen_a_sched
    import kyber_params_pkg::*;
#(
    parameter int unsigned K = KYBER_K
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              transpose,
    output logic              busy,
    output logic              done,
    output logic              xof_start,
    output logic [BYTE_W-1:0] xof_b0,
    output logic [BYTE_W-1:0] xof_b1,
    input  logic              xof_done,
    output logic              parse_start,
    input  logic              parse_done,
    output logic              poly_valid,
    input  logic              poly_ready,
    output logic [SLOT_W-1:0] poly_slot
);

    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    sched_state_e  state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic          tr_q, tr_d;
    logic          last_slot;

    // Next-state and index advance
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        tr_d      = tr_q;
        last_slot = (i_q == IW'(K - 1)) && (j_q == IW'(K - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    tr_d    = transpose;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = XOF_REQ;
                end
            end
            XOF_REQ:   state_d = XOF_WAIT;
            XOF_WAIT:  if (xof_done) state_d = PARSE_REQ;
            PARSE_REQ: state_d = PARSE_WAIT;
            PARSE_WAIT: if (parse_done) state_d = EMIT;
            EMIT: begin
                if (poly_ready) begin
                    if (last_slot) begin
                        i_d     = '0;
                        j_d     = '0;
                        state_d = FIN;
                    end else begin
                        state_d = XOF_REQ;
                        if (j_q == IW'(K - 1)) begin
                            j_d = '0;
                            i_d = i_q + IW'(1);
                        end else begin
                            j_d = j_q + IW'(1);
                        end
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, indices and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            tr_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            xof_start   <= 1'b0;
            parse_start <= 1'b0;
            poly_valid  <= 1'b0;
            xof_b0      <= '0;
            xof_b1      <= '0;
            poly_slot   <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            tr_q        <= tr_d;
            busy        <= (state_d != IDLE) && (state_d != FIN);
            done        <= (state_d == FIN);
            xof_start   <= (state_d == XOF_REQ);
            parse_start <= (state_d == PARSE_REQ);
            poly_valid  <= (state_d == EMIT);
            xof_b0      <= tr_d ? BYTE_W'(i_d) : BYTE_W'(j_d);
            xof_b1      <= tr_d ? BYTE_W'(j_d) : BYTE_W'(i_d);
            poly_slot   <= SLOT_W'(i_d) * SLOT_W'(K) + SLOT_W'(j_d);
        end
    end

endmodule

// File: tb/tb_gen_a_sched.sv
// Directed bench for gen_a_sched: per-slot expectation table driven through
// scenario records, plus hand-written reset and restart sequences.
module tb_gen_a_sched;

    localparam int XL = 3;   // xof_done this many cycles after xof_start
    localparam int PL = 20;  // parse_done this many cycles after parse_start
    localparam int NS = 9;

    logic       clk;
    logic       rst;
    logic       start;
    logic       transpose;
    logic       busy;
    logic       done;
    logic       xof_start;
    logic [7:0] xof_b0;
    logic [7:0] xof_b1;
    logic       xof_done;
    logic       parse_start;
    logic       parse_done;
    logic       poly_valid;
    logic       poly_ready;
    logic [3:0] poly_slot;

    gen_a_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .transpose   (transpose),
        .busy        (busy),
        .done        (done),
        .xof_start   (xof_start),
        .xof_b0      (xof_b0),
        .xof_b1      (xof_b1),
        .xof_done    (xof_done),
        .parse_start (parse_start),
        .parse_done  (parse_done),
        .poly_valid  (poly_valid),
        .poly_ready  (poly_ready),
        .poly_slot   (poly_slot)
    );

    typedef struct {
        logic [3:0] slot;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] tb0;
        logic [7:0] tb1;
    } vec_t;

    typedef struct {
        logic tr;
        int   stall_slot;
        int   stall_len;
        int   spur_parse;
        int   busy_start;
        int   abort_slot;
    } scn_t;

    vec_t vec [NS];
    scn_t scn [4];

    int checks;
    int failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_xof_start"}, 32'(xof_start), 0);
        chk({tag, "_parse_start"}, 32'(parse_start), 0);
        chk({tag, "_poly_valid"}, 32'(poly_valid), 0);
        chk({tag, "_b0"}, 32'(xof_b0), 0);
        chk({tag, "_b1"}, 32'(xof_b1), 0);
        chk({tag, "_slot"}, 32'(poly_slot), 0);
    endtask

    // Runs one matrix from IDLE; returns at the FIN negedge, or right after an abort reset.
    task automatic run(input int sc);
        logic       tr;
        logic [7:0] eb0;
        logic [7:0] eb1;
        tr = scn[sc].tr;
        start = 1'b1;
        transpose = tr;
        @(negedge clk);
        start = 1'b0;
        transpose = ~tr;
        for (int s = 0; s < NS; s++) begin
            eb0 = tr ? vec[s].tb0 : vec[s].b0;
            eb1 = tr ? vec[s].tb1 : vec[s].b1;
            chk("xof_start_lat", 32'(xof_start), 1);
            chk("busy_run", 32'(busy), 1);
            chk("valid_in_xreq", 32'(poly_valid), 0);
            chk("b0_req", 32'(xof_b0), 32'(eb0));
            chk("b1_req", 32'(xof_b1), 32'(eb1));
            if (s == scn[sc].busy_start) begin
                start = 1'b1;
                transpose = ~tr;
            end
            for (int c = 1; c < XL; c++) begin
                @(negedge clk);
                start = 1'b0;
                chk("xof_start_width", 32'(xof_start), 0);
                chk("parse_start_xwait", 32'(parse_start), 0);
                chk("valid_xwait", 32'(poly_valid), 0);
                chk("b0_hold_x", 32'(xof_b0), 32'(eb0));
                parse_done = (c == 1 && s == scn[sc].spur_parse);
            end
            @(negedge clk);
            parse_done = 1'b0;
            chk("parse_start_spur", 32'(parse_start), 0);
            chk("valid_spur", 32'(poly_valid), 0);
            xof_done = 1'b1;
            @(negedge clk);
            xof_done = 1'b0;
            chk("parse_start_lat", 32'(parse_start), 1);
            chk("xof_start_quiet", 32'(xof_start), 0);
            for (int c = 1; c < PL; c++) begin
                @(negedge clk);
                chk("parse_start_width", 32'(parse_start), 0);
                chk("valid_pwait", 32'(poly_valid), 0);
                if (s == scn[sc].abort_slot && c == 2) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk_idle_zero("abort");
                    return;
                end
            end
            @(negedge clk);
            parse_done = 1'b1;
            if (s == scn[sc].stall_slot) poly_ready = 1'b0;
            @(negedge clk);
            parse_done = 1'b0;
            chk("valid_lat", 32'(poly_valid), 1);
            chk("slot", 32'(poly_slot), 32'(vec[s].slot));
            chk("b0_emit", 32'(xof_b0), 32'(eb0));
            chk("b1_emit", 32'(xof_b1), 32'(eb1));
            if (s == scn[sc].stall_slot) begin
                for (int c = 1; c < scn[sc].stall_len; c++) begin
                    xof_done = (c == 1);
                    @(negedge clk);
                    chk("valid_stall", 32'(poly_valid), 1);
                    chk("slot_stall", 32'(poly_slot), 32'(vec[s].slot));
                    chk("xof_start_stall", 32'(xof_start), 0);
                    chk("parse_start_stall", 32'(parse_start), 0);
                end
                xof_done = 1'b0;
                poly_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_pulse", 32'(done), 1);
        chk("busy_fin", 32'(busy), 0);
        chk("valid_fin", 32'(poly_valid), 0);
        chk("xof_start_fin", 32'(xof_start), 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        vec[0] = '{4'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vec[1] = '{4'd1, 8'd1, 8'd0, 8'd0, 8'd1};
        vec[2] = '{4'd2, 8'd2, 8'd0, 8'd0, 8'd2};
        vec[3] = '{4'd3, 8'd0, 8'd1, 8'd1, 8'd0};
        vec[4] = '{4'd4, 8'd1, 8'd1, 8'd1, 8'd1};
        vec[5] = '{4'd5, 8'd2, 8'd1, 8'd1, 8'd2};
        vec[6] = '{4'd6, 8'd0, 8'd2, 8'd2, 8'd0};
        vec[7] = '{4'd7, 8'd1, 8'd2, 8'd2, 8'd1};
        vec[8] = '{4'd8, 8'd2, 8'd2, 8'd2, 8'd2};
        //        tr    stall len spur busy abort
        scn[0] = '{1'b0, -1,   0,  2,   3,   -1};
        scn[1] = '{1'b1,  4,   5,  7,   1,   -1};
        scn[2] = '{1'b0, -1,   0, -1,  -1,    5};
        scn[3] = '{1'b0,  4,   5,  0,   4,   -1};

        rst = 1'b1;
        start = 1'b0;
        transpose = 1'b0;
        xof_done = 1'b0;
        parse_done = 1'b0;
        poly_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");

        // start held during the last reset cycle must be dropped
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio_xof_start", 32'(xof_start), 0);
        chk("rst_prio_busy", 32'(busy), 0);

        for (int sc = 0; sc < 4; sc++) begin
            run(sc);
            if (scn[sc].abort_slot < 0) begin
                // start during FIN is ignored; the next cycle is IDLE again
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("post_fin_done", 32'(done), 0);
                chk("post_fin_busy", 32'(busy), 0);
                chk("start_in_fin_ignored", 32'(xof_start), 0);
            end
        end

        repeat (3) @(negedge clk);
        chk("final_busy", 32'(busy), 0);
        chk("final_done", 32'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
